// File: rtl/spi_slave.sv
// SPI mode-0 slave: deserialises MOSI frames into rx_data, serialises the buffered tx word onto MISO.
// Latency: rx_valid pulses 3 clk after the raw final sclk rising edge (2-flop sync + edge detect).
// Backpressure: none; the master paces the link, rx_data is overwritten by the next good frame.
//
// Ports:
//   clk, nrst          system clock, synchronous active-low reset
//   sclk, ss, mosi     raw SPI inputs from the master, asynchronous to clk
//   miso               TX shift register MSB while a frame is in progress, else 0
//   tx_data, tx_load   word to return in the next frame, captured by a one-clk strobe
//   rx_data, rx_valid  last complete received word and its one-clk update pulse
//   busy               high while a frame is being shifted
//   frame_err          one-clk pulse when ss rises before a full frame has been clocked

module spi_slave #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err
);

    localparam int                CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // ------------------------------------------------------------------
    // Input synchronisers; the third flop on sclk/ss gives edge detection
    // ------------------------------------------------------------------
    logic sclk_s1, sclk_s2, sclk_s3;
    logic ss_s1, ss_s2, ss_s3;
    logic mosi_s1, mosi_s2;

    // settle marks when ss_s2 holds a genuinely sampled value rather than the
    // reset preset. armed is only set once ss has really been seen high, so a
    // master holding ss low across reset cannot start a frame until it
    // deselects and reselects the slave.
    logic [1:0] settle;
    logic       armed;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_s3   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            settle  <= 2'b00;
            armed   <= 1'b0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            ss_s1   <= ss;
            ss_s2   <= ss_s1;
            ss_s3   <= ss_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
            settle  <= {settle[0], 1'b1};
            if (settle[1] && ss_s2) begin
                armed <= 1'b1;
            end
        end
    end

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign ss_rise   = ss_s2 & ~ss_s3;
    assign ss_fall   = ~ss_s2 & ss_s3;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] tx_buf;
    logic [DATA_W-1:0] rx_next;

    // Control strobes decoded by the FSM
    logic start_frame;
    logic rx_shift;
    logic tx_shift;
    logic frame_done;
    logic frame_abort;

    // RX register with the bit being sampled this clk appended
    assign rx_next = {rx_sr[DATA_W-2:0], mosi_s2};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        rx_shift    = 1'b0;
        tx_shift    = 1'b0;
        frame_done  = 1'b0;
        frame_abort = 1'b0;

        case (state_q)
            IDLE: begin
                if (ss_fall && armed) begin
                    state_d     = SHIFT;
                    start_frame = 1'b1;
                end
            end

            SHIFT: begin
                // ss wins over a coincident final sclk edge, so a frame
                // only completes if the master keeps ss low through it.
                // Completion is taken on the last rising edge itself, so the
                // counter only reaches DATA_W on the way into DONE.
                if (ss_rise) begin
                    state_d     = IDLE;
                    frame_abort = 1'b1;
                end else begin
                    if (sclk_rise) begin
                        rx_shift = 1'b1;
                        if (bit_cnt == CNT_LAST) begin
                            state_d    = DONE;
                            frame_done = 1'b1;
                        end
                    end
                    // The first falling edge after ss drops precedes any
                    // sampling edge, so the MSB must stay put until bit 0
                    // has actually been clocked.
                    if (sclk_fall && (bit_cnt != '0)) begin
                        tx_shift = 1'b1;
                    end
                end
            end

            DONE: begin
                // Surplus sclk pulses are ignored; wait for deselect.
                if (ss_rise) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift registers, counter, buffers and pulse outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            tx_buf    <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= frame_done;
            frame_err <= frame_abort;

            if (start_frame) begin
                bit_cnt <= '0;
                tx_sr   <= tx_buf;
            end

            if (rx_shift) begin
                rx_sr   <= rx_next;
                bit_cnt <= bit_cnt + CNT_ONE;
            end

            if (frame_done) begin
                rx_data <= rx_next;
            end

            if (tx_shift) begin
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end

            // The buffer is frozen while shifting; the word in flight lives
            // in tx_sr and is never touched by a load.
            if (tx_load && (state_q != SHIFT)) begin
                tx_buf <= tx_data;
            end
        end
    end

    assign busy = (state_q == SHIFT);
    assign miso = (state_q == SHIFT) ? tx_sr[DATA_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    localparam int HP = 5; // sclk half period in clk cycles

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        sclk = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [15:0] tx_data = 16'h0;
    logic        tx_load = 1'b0;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        frame_err;

    spi_slave #(.DATA_W(16)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .sclk      (sclk),
        .ss        (ss),
        .mosi      (mosi),
        .miso      (miso),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int rxv_cnt = 0;
    int ferr_cnt = 0;
    int cyc = 0;
    int rxv_cyc = 0;
    int rise16_cyc = 0;
    logic busy_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt = rxv_cnt + 1;
            rxv_cyc = cyc;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic load_tx(input logic [15:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // Mode-0 master clocking n pulses; miso sampled just before each rising edge.
    task automatic pulses(input logic [15:0] w, input int n, input logic ml,
                          input logic [15:0] mv, output logic [15:0] got);
        got = 16'h0;
        for (int i = 0; i < n; i++) begin
            mosi = (i < 16) ? w[15-i] : 1'b1;
            repeat (HP) @(negedge clk);
            if (i < 16) got[15-i] = miso;
            sclk = 1'b1;
            if (i == 15) rise16_cyc = cyc;
            if (i == 1) busy_seen = busy;
            if (ml && i == 4) begin
                tx_data = mv;
                tx_load = 1'b1;
                @(negedge clk);
                tx_load = 1'b0;
                repeat (HP - 1) @(negedge clk);
            end else begin
                repeat (HP) @(negedge clk);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic do_frame(input logic [15:0] w, input int n, input logic ml,
                            input logic [15:0] mv, output logic [15:0] got);
        ss = 1'b0;
        repeat (8) @(negedge clk);
        pulses(w, n, ml, mv, got);
        repeat (8) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic        ld;
        logic [15:0] ld_val;
        logic [15:0] w;
        int          n;
        logic        ml;
        logic [15:0] mv;
        logic [15:0] exp_rx;
        int          exp_v;
        int          exp_e;
        logic [15:0] exp_miso;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [15:0] got;
        logic [15:0] m_buf;
        logic [15:0] m_rx;
        logic [15:0] mask;
        int v0, e0, n, kind, nb;
        logic ld, ml;
        logic [15:0] val, w, mv;

        //            ld    ld_val    w         n   ml    mv        exp_rx    v  e  exp_miso
        vt[0] = '{1'b1, 16'hA5C3, 16'h1234, 16, 1'b0, 16'h0000, 16'h1234, 1, 0, 16'hA5C3};
        vt[1] = '{1'b1, 16'h5A5A, 16'hFFFF, 16, 1'b0, 16'h0000, 16'hFFFF, 1, 0, 16'h5A5A};
        vt[2] = '{1'b0, 16'h0000, 16'h0000, 16, 1'b0, 16'h0000, 16'h0000, 1, 0, 16'h5A5A};
        vt[3] = '{1'b0, 16'h0000, 16'hBEEF,  9, 1'b0, 16'h0000, 16'h0000, 0, 1, 16'h5A00};
        vt[4] = '{1'b1, 16'hAAAA, 16'h1111, 16, 1'b1, 16'h0F0F, 16'h1111, 1, 0, 16'hAAAA};
        vt[5] = '{1'b0, 16'h0000, 16'h2222, 16, 1'b0, 16'h0000, 16'h2222, 1, 0, 16'hAAAA};
        vt[6] = '{1'b1, 16'h3C3C, 16'h8001, 17, 1'b0, 16'h0000, 16'h8001, 1, 0, 16'h3C3C};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_miso", 32'(miso), 32'h0);
        nrst = 1'b1;
        repeat (6) @(negedge clk);

        // Directed table
        for (int k = 0; k < 7; k++) begin
            if (vt[k].ld) load_tx(vt[k].ld_val);
            v0 = rxv_cnt;
            e0 = ferr_cnt;
            busy_seen = 1'b0;
            do_frame(vt[k].w, vt[k].n, vt[k].ml, vt[k].mv, got);
            chk($sformatf("tbl%0d_rx_data", k), 32'(rx_data), 32'(vt[k].exp_rx));
            chk($sformatf("tbl%0d_rx_valid_cnt", k), rxv_cnt - v0, vt[k].exp_v);
            chk($sformatf("tbl%0d_frame_err_cnt", k), ferr_cnt - e0, vt[k].exp_e);
            chk($sformatf("tbl%0d_miso", k), 32'(got), 32'(vt[k].exp_miso));
            chk($sformatf("tbl%0d_busy_mid", k), 32'(busy_seen), 32'h1);
            chk($sformatf("tbl%0d_busy_after", k), 32'(busy), 32'h0);
            if (vt[k].exp_v == 1)
                chk($sformatf("tbl%0d_latency", k),
                    32'((rxv_cyc - rise16_cyc) >= 1 && (rxv_cyc - rise16_cyc) <= 4), 32'h1);
        end

        // Reset mid-frame with ss held low
        v0 = rxv_cnt;
        e0 = ferr_cnt;
        ss = 1'b0;
        repeat (8) @(negedge clk);
        pulses(16'hFFFF, 5, 1'b0, 16'h0, got);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_rx_data", 32'(rx_data), 32'h0);
        busy_seen = 1'b0;
        pulses(16'hFFFF, 16, 1'b0, 16'h0, got);
        repeat (10) @(negedge clk);
        chk("midrst_busy_seen", 32'(busy_seen), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_rx_valid_cnt", rxv_cnt - v0, 0);
        chk("midrst_frame_err_cnt", ferr_cnt - e0, 0);
        ss = 1'b1;
        repeat (8) @(negedge clk);
        do_frame(16'hC0DE, 16, 1'b0, 16'h0, got);
        chk("postrst_rx_data", 32'(rx_data), 32'hC0DE);
        chk("postrst_rx_valid_cnt", rxv_cnt - v0, 1);
        chk("postrst_miso", 32'(got), 32'h0);

        // Randomised frames against the reference model
        m_buf = 16'h0;
        m_rx  = 16'hC0DE;
        for (int r = 0; r < 24; r++) begin
            ld   = 1'($urandom_range(0, 1));
            val  = 16'($urandom);
            w    = 16'($urandom);
            ml   = 1'($urandom_range(0, 1));
            mv   = 16'($urandom);
            kind = $urandom_range(0, 3);
            n    = (kind == 0) ? $urandom_range(1, 15) : (kind == 1) ? 17 : 16;
            if (ld) begin
                load_tx(val);
                m_buf = val;
            end
            nb   = (n > 16) ? 16 : n;
            mask = 16'hFFFF << (16 - nb);
            if (n >= 16) m_rx = w;
            v0 = rxv_cnt;
            e0 = ferr_cnt;
            do_frame(w, n, ml, mv, got);
            chk($sformatf("rnd%0d_rx_data", r), 32'(rx_data), 32'(m_rx));
            chk($sformatf("rnd%0d_rx_valid_cnt", r), rxv_cnt - v0, (n >= 16) ? 1 : 0);
            chk($sformatf("rnd%0d_frame_err_cnt", r), ferr_cnt - e0, (n < 16) ? 1 : 0);
            chk($sformatf("rnd%0d_miso", r), 32'(got), 32'(m_buf & mask));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 16, frame length in bits.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge clk.
REQ-003 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port sclk  input  1  SPI serial clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-005 SHALL have port ss  input  1  slave select, active-low, asynchronous to clk.
REQ-006 SHALL have port mosi  input  1  serial data from master, MSB first.
REQ-007 SHALL have port miso  output  1  serial data to master, MSB first.
REQ-008 SHALL have port tx_data  input  DATA_W  word to be returned in the next frame.
REQ-009 SHALL have port tx_load  input  1  one-clk strobe capturing tx_data into the transmit buffer.
REQ-010 SHALL have port rx_data  output  DATA_W  last completely received word.
REQ-011 SHALL have port rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-012 SHALL have port busy  output  1  high while in SHIFT.
REQ-013 SHALL have port frame_err  output  1  one-clk pulse on an aborted frame.

Function
REQ-014 SHALL pass sclk, ss and mosi each through a 2-flop synchronizer; edges are detected using a third flop on synchronized sclk and ss.
REQ-015 SHALL require each sclk phase to last at least 2 clk periods; faster sclk is out of scope.
REQ-016 SHALL implement FSM states IDLE, SHIFT and DONE; unused encodings go to IDLE.
REQ-017 IDLE: on a synchronized ss falling edge, go to SHIFT, clear the bit counter to 0, and load the TX shift register from the transmit buffer.
REQ-018 SHIFT: on each synchronized sclk rising edge, shift synchronized mosi into the LSB of the RX shift register and increment the bit counter.
REQ-019 SHIFT: on each synchronized sclk falling edge with counter != 0, shift the TX shift register left by one bit.
REQ-020 miso SHALL equal the TX shift register MSB in SHIFT and 0 otherwise.
REQ-021 SHIFT -> DONE SHALL occur when counter == DATA_W; on that transition rx_data <= RX shift register and rx_valid = 1 for exactly one clk.
REQ-022 The counter SHALL be $clog2(DATA_W)+1 bits wide, SHALL never exceed DATA_W, and SHALL NOT wrap.
REQ-023 DONE: sclk edges SHALL be ignored; a synchronized ss rising edge SHALL go to IDLE.
REQ-024 A synchronized ss rising edge in SHIFT with counter < DATA_W SHALL go to IDLE, pulse frame_err for one clk, and leave rx_data unchanged with no rx_valid.
REQ-025 A synchronized ss rising edge and the DATA_W-th sclk rising edge detected in the same clk SHALL be treated as an abort per REQ-024 (ss has priority).
REQ-026 tx_load SHALL update the transmit buffer in IDLE and DONE; in SHIFT it SHALL be ignored and the buffer kept.
REQ-027 The frame already loaded into the TX shift register SHALL be unaffected by any tx_load.
REQ-028 busy SHALL be 1 exactly when the state is SHIFT.
REQ-029 The rx_valid pulse SHALL appear no later than 4 clk after the raw final sclk rising edge.

Reset
REQ-030 When nrst=0 at posedge clk, the block SHALL enter IDLE and clear the counter, shift registers, transmit buffer and rx_data to 0.
REQ-031 Reset SHALL drive rx_valid=0, frame_err=0, busy=0 and miso=0.
REQ-032 Reset SHALL preset the ss synchronizer and edge flops to 1 and the sclk flops to 0.
REQ-033 If ss is low at reset release, no frame SHALL start until ss goes high and then low again.
REQ-034 Reset asserted mid-frame SHALL abort the frame silently, with no rx_valid and no frame_err.

Verification
REQ-035 tx_load with tx_data=16'hA5C3, then a 16-bit frame with mosi=16'h1234 -> rx_data=16'h1234 with a single rx_valid pulse; master samples miso as 16'hA5C3.
REQ-036 Two back-to-back frames with mosi 16'hFFFF then 16'h0000, ss high between them -> two rx_valid pulses; rx_data ends at 16'h0000.
REQ-037 ss raised after 9 sclk cycles -> frame_err pulse, no rx_valid; rx_data keeps its previous value; busy falls.
REQ-038 tx_load with 16'h0F0F mid-frame while the frame sends 16'hAAAA -> miso carries 16'hAAAA; the next frame carries the previously buffered value, not 16'h0F0F.
REQ-039 nrst pulsed after 5 sclk cycles with ss held low -> no rx_valid or frame_err; no frame until ss toggles high then low.
REQ-040 A 17th sclk pulse in DONE before ss rises -> ignored; rx_data unchanged, exactly one rx_valid.
